// File: rtl/pipeline_trace_monitor_pkg.sv
// Shared definitions for the pipeline trace monitor and the CPU top that hosts it.
package pipeline_trace_monitor_pkg;

  // Default trace payload and timestamp widths, matched to the CPU write-back path.
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_TS_W   = 16;

  // Monitor run state; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_trace_monitor_trace_fifo.sv
// trace_fifo: show-ahead FIFO holding retired-instruction trace entries.
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   clear                 - synchronous flush (empties FIFO on the edge)
//   wr_req, wr_data       - write request; taken when not full or when a pop frees a slot
//   rd_ready              - consumer pops the head when rd_valid is high
//   rd_valid, rd_data     - head entry, visible combinationally
//   full                  - all DEPTH entries occupied
module trace_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty_c;
  logic             pop_c;
  logic             push_c;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_c  = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c    = !empty_c && rd_ready;
  assign push_c   = wr_req && (!full || pop_c);

  assign rd_valid = !empty_c;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // Pointer update; a flush overrides any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed behind rd_valid.
  always_ff @(posedge clock) begin
    if (push_c && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pipeline_trace_monitor.sv
// pipeline_trace_monitor: counts cycles, stalls and retirements during a CPU run
// and queues a timestamped trace entry for every retired instruction.
// Ports:
//   clock, reset                 - clock, asynchronous active-low reset
//   start, halt                  - begin/restart a run, end a run (start wins)
//   stall, retire_valid          - per-cycle pipeline events
//   retire_data                  - write-back payload of the retiring instruction
//   rd_ready / rd_valid, rd_data - show-ahead trace read port ({timestamp, payload})
//   cycle/retire/stall/drop_count- saturating run statistics
//   state                        - IDLE=0, RUN=1, HALTED=2
//   overflow                     - sticky, a trace entry was dropped this run
module pipeline_trace_monitor
  import pipeline_trace_monitor_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CYC_W  = 32,
  parameter int unsigned TS_W   = DEF_TS_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   stall,
  input  logic                   retire_valid,
  input  logic [DATA_W-1:0]      retire_data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [TS_W+DATA_W-1:0] rd_data,
  output logic [CYC_W-1:0]       cycle_count,
  output logic [CYC_W-1:0]       retire_count,
  output logic [CYC_W-1:0]       stall_count,
  output logic [CYC_W-1:0]       drop_count,
  output logic [1:0]             state,
  output logic                   overflow
);

  state_t                 state_q;
  logic                   wr_req_c;
  logic                   full_c;
  logic                   pop_c;
  logic                   drop_c;
  logic [TS_W+DATA_W-1:0] wr_data_c;

  assign state = state_q;

  // Only retirements inside a run (and not on a restart edge) are traced.
  assign wr_req_c  = (state_q == ST_RUN) && !start && retire_valid;
  assign wr_data_c = {TS_W'(cycle_count), retire_data};
  assign pop_c     = rd_valid && rd_ready;
  assign drop_c    = wr_req_c && full_c && !pop_c;

  trace_fifo #(
    .WIDTH (TS_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (start),
    .wr_req   (wr_req_c),
    .wr_data  (wr_data_c),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .full     (full_c)
  );

  // Run FSM and statistics; counters add 1 only while not all-ones (saturate).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cycle_count  <= '0;
      retire_count <= '0;
      stall_count  <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else if (start) begin
      state_q      <= ST_RUN;
      cycle_count  <= '0;
      retire_count <= '0;
      stall_count  <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cycle_count <= cycle_count + CYC_W'(~&cycle_count);
          if (stall)        stall_count  <= stall_count + CYC_W'(~&stall_count);
          if (retire_valid) retire_count <= retire_count + CYC_W'(~&retire_count);
          if (drop_c) begin
            drop_count <= drop_count + CYC_W'(~&drop_count);
            overflow   <= 1'b1;
          end
          if (halt) state_q <= ST_HALTED;
        end
        default: ;
      endcase
    end
  end

endmodule
